// File: rtl/pid_cntrl_param_if.sv
// Purpose: sample/control bundle between a PID controller and its client.
// Signals:
//   vld     - err carries a new sample this cycle
//   err     - signed error sample (IN_W)
//   clr_int - synchronous integrator clear
//   pid_out - signed registered control output (OUT_W)
//   out_vld - vld delayed by one clock
//   out_sat - pid_out was clamped this cycle
// Modports: master drives samples and reads results; slave is the controller.
interface pid_cntrl_param_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 16
);
    logic                    vld;
    logic signed [IN_W-1:0]  err;
    logic                    clr_int;
    logic signed [OUT_W-1:0] pid_out;
    logic                    out_vld;
    logic                    out_sat;

    modport master (
        output vld, err, clr_int,
        input  pid_out, out_vld, out_sat
    );

    modport slave (
        input  vld, err, clr_int,
        output pid_out, out_vld, out_sat
    );
endinterface

// File: rtl/pid_cntrl_param.sv
// Purpose: parameterised PID controller with saturating error, integrator,
//          D history queue and saturated, registered output.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - pid_cntrl_param_if slave (vld, err, clr_int in; pid_out,
//           out_vld, out_sat out)
// INT_W is expected to be at least ERR_W+7 so the integrator has headroom.
module pid_cntrl_param #(
    parameter int unsigned IN_W    = 16,
    parameter int unsigned ERR_W   = 10,
    parameter int unsigned INT_W   = 18,
    parameter int unsigned I_SHIFT = 6,
    parameter int unsigned D_DEPTH = 2,
    parameter int unsigned P_COEFF = 14,
    parameter int unsigned D_COEFF = 20,
    parameter int unsigned OUT_W   = 16,
    parameter bit          AW_EN   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    pid_cntrl_param_if.slave bus
);

    // Coefficients are carried as non-negative 33-bit signed values so the
    // products stay exact for any 32-bit unsigned coefficient.
    localparam int unsigned K_W   = 33;
    localparam int unsigned M_W   = ERR_W + K_W;
    localparam int unsigned SUM_W = ((M_W > INT_W) ? M_W : INT_W) + 2;

    localparam logic signed [K_W-1:0]   P_K     = K_W'(P_COEFF);
    localparam logic signed [K_W-1:0]   D_K     = K_W'(D_COEFF);
    localparam logic signed [IN_W-1:0]  ERR_MAX = {{(IN_W-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0]  ERR_MIN = {{(IN_W-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OUT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ERR_W-1:0]            err_sat;
    logic signed [ERR_W:0]              d_raw;
    logic signed [ERR_W-1:0]            d_diff;
    logic signed [M_W-1:0]              p_term;
    logic signed [M_W-1:0]              d_term;
    logic signed [INT_W-1:0]            i_term;
    logic signed [SUM_W-1:0]            sum;
    logic signed [INT_W:0]              int_sum;
    logic signed [INT_W-1:0]            int_sat;
    logic                               aw_hold;

    logic signed [INT_W-1:0]            int_q, int_d;
    logic [D_DEPTH-1:0][ERR_W-1:0]      dq_q, dq_d;
    logic signed [OUT_W-1:0]            pid_out_q, pid_out_d;
    logic                               out_sat_q, out_sat_d;
    logic                               out_vld_q;

    // Clamp the incoming error into the ERR_W signed range.
    always_comb begin
        if (bus.err > ERR_MAX) begin
            err_sat = ERR_MAX[ERR_W-1:0];
        end else if (bus.err < ERR_MIN) begin
            err_sat = ERR_MIN[ERR_W-1:0];
        end else begin
            err_sat = bus.err[ERR_W-1:0];
        end
    end

    // D difference against the oldest queued sample, saturated to ERR_W.
    always_comb begin
        d_raw = (ERR_W+1)'(err_sat) - (ERR_W+1)'($signed(dq_q[D_DEPTH-1]));
        if (d_raw[ERR_W] != d_raw[ERR_W-1]) begin
            d_diff = d_raw[ERR_W] ? {1'b1, {(ERR_W-1){1'b0}}} : {1'b0, {(ERR_W-1){1'b1}}};
        end else begin
            d_diff = d_raw[ERR_W-1:0];
        end
    end

    // Full-width P + I + D, then clamp to the output range.
    always_comb begin
        p_term    = M_W'(err_sat) * M_W'(P_K);
        d_term    = M_W'(d_diff) * M_W'(D_K);
        i_term    = int_q >>> I_SHIFT;
        sum       = SUM_W'(p_term) + SUM_W'(i_term) + SUM_W'(d_term);
        out_sat_d = 1'b0;
        pid_out_d = sum[OUT_W-1:0];
        if (sum > OUT_MAX) begin
            pid_out_d = OUT_MAX[OUT_W-1:0];
            out_sat_d = 1'b1;
        end else if (sum < OUT_MIN) begin
            pid_out_d = OUT_MIN[OUT_W-1:0];
            out_sat_d = 1'b1;
        end
    end

    // Integrator: saturating accumulate on vld, clear wins, optional anti-windup
    // skips updates that would push further into the current output clamp.
    always_comb begin
        aw_hold = AW_EN && out_sat_q && (err_sat[ERR_W-1] == pid_out_q[OUT_W-1]);
        int_sum = (INT_W+1)'(int_q) + (INT_W+1)'(err_sat);
        if (int_sum[INT_W] != int_sum[INT_W-1]) begin
            int_sat = int_sum[INT_W] ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
        end else begin
            int_sat = int_sum[INT_W-1:0];
        end
        int_d = int_q;
        if (bus.clr_int) begin
            int_d = '0;
        end else if (bus.vld && !aw_hold) begin
            int_d = int_sat;
        end
    end

    // D history shifts on every vld, including a cycle that also clears.
    always_comb begin
        dq_d = dq_q;
        if (bus.vld) begin
            for (int unsigned i = D_DEPTH - 1; i > 0; i--) begin
                dq_d[i] = dq_q[i-1];
            end
            dq_d[0] = err_sat;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q     <= '0;
            dq_q      <= '0;
            pid_out_q <= '0;
            out_sat_q <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            int_q     <= int_d;
            dq_q      <= dq_d;
            pid_out_q <= pid_out_d;
            out_sat_q <= out_sat_d;
            out_vld_q <= bus.vld;
        end
    end

    assign bus.pid_out = pid_out_q;
    assign bus.out_sat = out_sat_q;
    assign bus.out_vld = out_vld_q;

endmodule

// File: tb/tb_pid_cntrl_param.sv
// Purpose: self-checking bench for pid_cntrl_param. Two instances share one
//          stimulus stream: defaults (AW off, 16-bit out) and AW on with a
//          12-bit output. A reference model computes the expected outputs.
module tb_pid_cntrl_param;

    localparam int D_DEPTH = 2;
    localparam int I_SHIFT = 6;
    localparam int P_COEFF = 14;
    localparam int D_COEFF = 20;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               vld;
    logic               clr;
    logic signed [15:0] err;

    always #5 clk = ~clk;

    pid_cntrl_param_if #(.IN_W(16), .OUT_W(16)) bus0 ();
    pid_cntrl_param_if #(.IN_W(16), .OUT_W(12)) bus1 ();

    assign bus0.vld = vld;
    assign bus0.err = err;
    assign bus0.clr_int = clr;
    assign bus1.vld = vld;
    assign bus1.err = err;
    assign bus1.clr_int = clr;

    pid_cntrl_param dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    pid_cntrl_param #(.OUT_W(12), .AW_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int checks = 0;
    int failures = 0;

    // Reference model state, index 0 = default instance, 1 = anti-windup instance.
    int mint[2];
    int mout[2];
    bit msat[2];
    bit mvld[2];
    int hist[$];   // err_sat of past vld samples, newest at the back

    function automatic int clamp(longint x, longint lo, longint hi);
        if (x > hi) return int'(hi);
        if (x < lo) return int'(lo);
        return int'(x);
    endfunction

    function automatic int ow(int k);
        return (k == 0) ? 16 : 12;
    endfunction

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mint[k] = 0;
            mout[k] = 0;
            msat[k] = 1'b0;
            mvld[k] = 1'b0;
        end
        hist.delete();
    endtask

    // One rising edge of the controller, evaluated from the current inputs.
    task automatic model_edge();
        int     es, oldest, dd, lim, no;
        longint s;
        bit     hold;
        es     = clamp(longint'(err), -512, 511);
        oldest = (hist.size() >= D_DEPTH) ? hist[hist.size() - D_DEPTH] : 0;
        dd     = clamp(longint'(es - oldest), -512, 511);
        for (int k = 0; k < 2; k++) begin
            s    = longint'(es) * P_COEFF + longint'(mint[k] >>> I_SHIFT) + longint'(dd) * D_COEFF;
            lim  = 1 << (ow(k) - 1);
            no   = clamp(s, -lim, lim - 1);
            hold = (k == 1) && msat[k] && ((es < 0) == (mout[k] < 0));
            if (clr) mint[k] = 0;
            else if (vld && !hold) mint[k] = clamp(longint'(mint[k]) + es, -131072, 131071);
            msat[k] = (longint'(no) != s);
            mout[k] = no;
            mvld[k] = vld;
        end
        if (vld) begin
            hist.push_back(es);
            if (hist.size() > D_DEPTH) void'(hist.pop_front());
        end
    endtask

    task automatic compare_all();
        check("pid0", int'(bus0.pid_out), mout[0]);
        check("sat0", int'(bus0.out_sat), int'(msat[0]));
        check("ovld0", int'(bus0.out_vld), int'(mvld[0]));
        check("int0", int'(dut0.int_q), mint[0]);
        check("pid1", int'(bus1.pid_out), mout[1]);
        check("sat1", int'(bus1.out_sat), int'(msat[1]));
        check("ovld1", int'(bus1.out_vld), int'(mvld[1]));
        check("int1", int'(dut1.int_q), mint[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    typedef struct {
        bit          v;
        logic [15:0] e;
        bit          c;
        int          es;
        int          pid;
        int          ig;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int tmp;

        // Hand-computed defaults: P=14*es, D=20*sat(es-oldest), I=int>>>6.
        tbl[0] = '{v:1'b0, e:16'h0000, c:1'b0, es:0,    pid:0,      ig:0};
        tbl[1] = '{v:1'b1, e:16'h0002, c:1'b0, es:2,    pid:68,     ig:2};
        tbl[2] = '{v:1'b1, e:16'h0002, c:1'b0, es:2,    pid:68,     ig:4};
        tbl[3] = '{v:1'b0, e:16'h0002, c:1'b0, es:2,    pid:28,     ig:4};
        tbl[4] = '{v:1'b1, e:16'h0300, c:1'b0, es:511,  pid:17334,  ig:515};
        tbl[5] = '{v:1'b1, e:16'hFD00, c:1'b0, es:-512, pid:-17400, ig:3};
        tbl[6] = '{v:1'b0, e:16'h0000, c:1'b1, es:0,    pid:-10220, ig:0};
        tbl[7] = '{v:1'b0, e:16'h0000, c:1'b0, es:0,    pid:-10220, ig:0};

        rst_n = 1'b0;
        vld   = 1'b0;
        clr   = 1'b0;
        err   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Directed table from reset.
        for (int i = 0; i < 8; i++) begin
            vld = tbl[i].v;
            err = tbl[i].e;
            clr = tbl[i].c;
            step();
            check("tbl_pid", int'(bus0.pid_out), tbl[i].pid);
            check("tbl_int", int'(dut0.int_q), tbl[i].ig);
            check("tbl_errsat", int'(dut0.err_sat), tbl[i].es);
        end

        // Integrator saturates positive without wrapping.
        vld = 1'b0; clr = 1'b1; err = '0;
        step();
        clr = 1'b0; vld = 1'b1; err = 16'h01FF;
        repeat (300) step();
        check("int_pos_sat", int'(dut0.int_q), 131071);

        // Negative mirror.
        vld = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0; vld = 1'b1; err = 16'hFE00;
        repeat (300) step();
        check("int_neg_sat", int'(dut0.int_q), -131072);

        // vld every other clock, err=2: 64 updates of 2.
        vld = 1'b0; clr = 1'b1; err = '0;
        step();
        clr = 1'b0; err = 16'd2;
        for (int i = 0; i < 128; i++) begin
            vld = (i % 2 == 0);
            step();
        end
        check("int_toggle", int'(dut0.int_q), 128);

        // clr with vld: integrator cleared, queue still shifts.
        vld = 1'b1; clr = 1'b1; err = 16'd5;
        step();
        check("clr_vld_int", int'(dut0.int_q), 0);
        clr = 1'b0; vld = 1'b0;
        step();

        // Anti-windup: clean start, drive into positive clamp, then back off.
        vld = 1'b1; clr = 1'b1; err = '0;
        repeat (3) step();
        clr = 1'b0; err = 16'h01FF;
        repeat (20) step();
        check("aw_freeze_int", int'(dut1.int_q), 511);
        check("aw_freeze_sat", int'(bus1.out_sat), 1);
        err = 16'hFFFF;
        repeat (20) step();
        check("aw_resume_int", int'(dut1.int_q), 493);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            vld = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0: begin
                    tmp = int'($urandom_range(0, 80)) - 40;
                    err = 16'(tmp);
                end
                1: err = 16'($urandom);
                default: begin
                    tmp = int'($urandom_range(0, 8)) - 4 + (($urandom_range(0, 1) == 1) ? 511 : -512);
                    err = 16'(tmp);
                end
            endcase
            step();
        end

        // Mid-stream asynchronous reset, checked before any clock edge.
        vld = 1'b1; clr = 1'b0; err = 16'h0100;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        vld = 1'b1; err = 16'd2;
        step();
        check("post_rst_first", int'(bus0.pid_out), 68);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pid_cntrl_param.md
PID_CNTRL_PARAM -- requirements
Module: pid_cntrl_param

Interface
REQ-001 Parameter IN_W, 16: width of the signed error input.
REQ-002 Parameter ERR_W, 10: width of the signed saturated error, err_sat.
REQ-003 Parameter INT_W, 18: width of the signed integrator; INT_W SHALL be at least ERR_W+7.
REQ-004 Parameter I_SHIFT, 6: arithmetic right shift applied to the integrator to form the I term.
REQ-005 Parameter D_DEPTH, 2: D-queue depth in vld samples; legal range 1..8.
REQ-006 Parameter P_COEFF, 14: unsigned proportional coefficient.
REQ-007 Parameter D_COEFF, 20: unsigned derivative coefficient.
REQ-008 Parameter OUT_W, 16: width of the signed output.
REQ-009 Parameter AW_EN, 0: 1 enables conditional-integration anti-windup.
REQ-010 clk  input  1  system clock; all flops SHALL be rising-edge.
REQ-011 rst_n  input  1  reset; asynchronous, active-low.
REQ-012 vld  input  1  qualifies err as a new sample.
REQ-013 err  input  IN_W  signed error.
REQ-014 clr_int  input  1  synchronous integrator clear.
REQ-015 pid_out  output  OUT_W  signed registered control output.
REQ-016 out_vld  output  1  vld delayed by one clock.
REQ-017 out_sat  output  1  high when pid_out is clamped this cycle.

Function
REQ-018 err_sat SHALL equal err clamped to the range [-2^(ERR_W-1), 2^(ERR_W-1)-1]; this is combinational (0x1FF / 0x200 at default widths).
REQ-019 The P term SHALL be err_sat*P_COEFF, a signed product with no truncation.
REQ-020 The integrator SHALL update only on vld, adding sign-extended err_sat and saturating at the INT_W signed maximum and minimum; it SHALL never wrap.
REQ-021 clr_int SHALL zero the integrator on the next edge and SHALL take priority over vld.
REQ-022 When AW_EN=1, a vld update SHALL be skipped if out_sat=1 and sign(err_sat) equals sign(pid_out).
REQ-023 When AW_EN=1, a vld update SHALL still proceed if err_sat opposes the direction of output saturation.
REQ-024 The I term SHALL be integrator>>>I_SHIFT.
REQ-025 The D queue SHALL be a D_DEPTH-entry shift register of err_sat that advances only on vld and holds otherwise.
REQ-026 The D difference SHALL be err_sat minus the oldest queue entry, saturated to ERR_W signed.
REQ-027 The D term SHALL be the D difference times D_COEFF.
REQ-028 The sum P+I+D SHALL be computed at full width, saturated to OUT_W signed, and registered into pid_out every clock, independent of vld.
REQ-029 Latency from err to pid_out SHALL be 1 clock.
REQ-030 The integrator and D-queue contributions to a vld cycle SHALL use their pre-update values (pre-edge state).
REQ-031 out_sat SHALL be registered alongside pid_out.
REQ-032 Simultaneous vld and clr_int SHALL clear the integrator while the D queue still shifts.
REQ-033 When vld is low, the integrator and D queue SHALL recirculate with no change.

Reset
REQ-034 Assertion of rst_n SHALL asynchronously zero the integrator, all D-queue entries, pid_out, out_vld and out_sat, including mid-operation.
REQ-035 The first post-reset sample SHALL see a zero D history.

Verification
REQ-036 Defaults: after reset with err=0, pid_out SHALL be 0; then vld=1, err=2 for one clock SHALL give pid_out=0x0044 (P=28, D=40, I=0).
REQ-037 err=0x0300 then 0xFD00 SHALL give err_sat=0x1FF and 0x200 respectively; err=2 held 2 vld clocks SHALL give pid_out=0x001C (D term zero).
REQ-038 err=0x01FF with vld=1 for 300 clocks SHALL saturate the integrator at 0x1FFFF with no wrap; the negative mirror SHALL reach 0x20000.
REQ-039 vld toggling every other clock with err=2 for 128 clocks SHALL give integrator=0x80; a D difference SHALL appear only on vld edges.
REQ-040 clr_int=1 with vld=1 SHALL give integrator=0 next clock; rst_n asserted mid-stream SHALL zero all outputs immediately, without waiting for clk.
REQ-041 AW_EN=1 with OUT_W=12 and err=0x1FF SHALL freeze the integrator while out_sat=1; err=-1 SHALL then resume decrementing.
